vc_evict_ds_rx: RTL
===================

# vc_evict_ds_rx

Downstream-side receiver for the vector cache evict data stream. Accepts `evict_to_ds_pld_t` beats (BUS_WIDTH data plus header) from the evict path, reassembles DS_N beats into one full cache-line payload, and presents it with the captured header on a valid/ready output. It serves as the memory-side endpoint and as the bench/model counterpart of the evict transmitter.

## Interface
- `BUS_WIDTH`, 128, beat data width in bits
- `DS_N`, 4, beats per line; power of two, ≥2
- `CNT_W`, 16, width of the completed-line counter

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_vld`  in  1  beat valid
- `in_rdy`  out  1  beat accepted when `in_vld && in_rdy`
- `in_pld`  in  $bits(evict_to_ds_pld_t)  beat: data, addr, last, rob_entry_id, db_entry_id, txnid, sideband
- `out_vld`  out  1  assembled line valid
- `out_rdy`  in  1  consumer ready
- `out_data`  out  DS_N*BUS_WIDTH  line; beat k in bits [k*BUS_WIDTH +: BUS_WIDTH]
- `out_addr`  out  $bits(addr_t)  addr from beat 0
- `out_rob_entry_id`  out  MSHR_ENTRY_IDX_WIDTH  from beat 0
- `out_db_entry_id`  out  DB_ENTRY_IDX_WIDTH  from beat 0
- `out_txnid`  out  $bits(txnid_t)  from beat 0
- `out_sideband`  out  SIDEBAND_WIDTH  from beat 0
- `out_beats`  out  $clog2(DS_N)+1  number of beats actually received
- `out_err`  out  1  protocol error flagged for this line
- `line_cnt`  out  CNT_W  lines delivered (handshakes on output), wraps

## Operation
- FSM states: COLLECT, FULL.
- COLLECT: `in_rdy`=1, `out_vld`=0. On each accepted beat, write data into slot `beat_cnt`, increment `beat_cnt`.
- Beat 0 (beat_cnt==0): capture header fields; clear line buffer slots 1..DS_N-1 to zero; clear err.
- Line end: accepted beat with beat_cnt==DS_N-1 → FULL next cycle, `out_beats`=DS_N.
- FULL: `in_rdy`=0, `out_vld`=1, all outputs stable until `out_rdy`. On `out_vld && out_rdy`: `line_cnt`+=1 (mod 2^CNT_W), beat_cnt←0, → COLLECT next cycle.
- `in_pld` ignored when `in_vld`=0. No beat is accepted in FULL even if `out_rdy`=1 that cycle.
- Reset: state COLLECT, beat_cnt 0, `in_rdy`=1 the cycle after reset deasserts, `out_vld`=0, `out_data`/header/`out_beats`/`out_err`=0, `line_cnt`=0. Reset mid-line discards partial line; reset in FULL drops pending line without counting it.

## Timing
- `in_rdy` and `out_vld` are registered-state decodes, no combinational path from `in_vld` or `out_rdy`.
- Latency: last beat accepted in cycle N → `out_vld`=1 in cycle N+1.
- Throughput: one line per DS_N+1 cycles minimum (DS_N beats + 1 output cycle with `out_rdy`=1).
- `out_data` for beat k visible one cycle after that beat's acceptance; consumer uses it only when `out_vld`=1.

## Configuration
- Macro `VC_EVICT_RX_CHK_EN`.
- Defined: protocol checking active.
  - `last`=1 on beat k<DS_N-1: line terminates early, → FULL, `out_beats`=k+1, unfilled slots zero, `out_err`=1.
  - `last`=0 on beat DS_N-1: line completes normally, `out_err`=1.
  - beats 1..: `addr.tag`/`addr.index` or `db_entry_id` differ from beat 0 → `out_err`=1 (data still stored).
- Not defined: `last` ignored; line ends solely on beat count; `out_beats` always DS_N when `out_vld`; `out_err` tied 0; no compare logic synthesized.

## Test plan
- Single line: 4 beats data 0x1..,0x2..,0x3..,0x4.., last on beat 3, `out_rdy`=1 → `out_vld` one cycle after beat 3, out_data[127:0]=beat0…[511:384]=beat3, header from beat 0, `out_beats`=4, `out_err`=0, `line_cnt`=1.
- Backpressure: `out_rdy`=0 for 10 cycles after FULL → `out_vld` and all outputs held, `in_rdy`=0 throughout; on `out_rdy`=1 one handshake, `in_rdy`=1 next cycle.
- Back-to-back: `in_vld` held high for 3 lines, `out_rdy`=1 → 3 lines delivered in 15 cycles, `line_cnt`=3, headers per line correct.
- Early last (CHK_EN): last on beat 1 → `out_beats`=2, out_data[511:256]=0, `out_err`=1; without macro → line waits for 4 beats, `out_err`=0.
- Header mismatch (CHK_EN): db_entry_id 5 on beat 0, 6 on beat 2 → `out_err`=1, `out_db_entry_id`=5.
- Reset mid-line after 2 beats, then full line → only the new line delivered, `line_cnt`=1; counter preloaded near wrap via 65536 lines (CNT_W=16) → wraps to 0.

Source files
------------

// File: rtl/vc_evict_ds_rx.sv
// Downstream receiver for the vector cache evict stream: gathers DS_N beats into one line
// and presents it with the beat-0 header. Define VC_EVICT_RX_CHK_EN to enable protocol checks.
package vc_evict_pkg;
  localparam int DEF_BUS_WIDTH        = 128;
  localparam int MSHR_ENTRY_IDX_WIDTH = 4;
  localparam int DB_ENTRY_IDX_WIDTH   = 4;
  localparam int SIDEBAND_WIDTH       = 8;
  localparam int TAG_W                = 20;
  localparam int INDEX_W              = 6;
  localparam int OFFSET_W             = 6;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_t;

  typedef logic [7:0] txnid_t;

  typedef struct packed {
    addr_t                           addr;
    logic                            last;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    txnid_t                          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } evict_hdr_t;

  typedef struct packed {
    logic [DEF_BUS_WIDTH-1:0] data;
    evict_hdr_t               hdr;
  } evict_to_ds_pld_t;
endpackage

module vc_evict_ds_rx
  import vc_evict_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DS_N      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  input  logic [BUS_WIDTH+$bits(evict_hdr_t)-1:0] in_pld,
  output logic                                   out_vld,
  input  logic                                   out_rdy,
  output logic [DS_N*BUS_WIDTH-1:0]              out_data,
  output addr_t                                  out_addr,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0]        out_rob_entry_id,
  output logic [DB_ENTRY_IDX_WIDTH-1:0]          out_db_entry_id,
  output txnid_t                                 out_txnid,
  output logic [SIDEBAND_WIDTH-1:0]              out_sideband,
  output logic [$clog2(DS_N):0]                  out_beats,
  output logic                                   out_err,
  output logic [CNT_W-1:0]                       line_cnt
);

  localparam int BC_W = $clog2(DS_N);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(DS_N - 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                  state_q, state_d;
  logic [BC_W-1:0]         beat_cnt_q;
  logic [DS_N*BUS_WIDTH-1:0] line_q;
  evict_hdr_t              hdr_q;
  logic [BC_W:0]           beats_q;
  logic [CNT_W-1:0]        line_cnt_q;

  logic [BUS_WIDTH-1:0]    in_data;
  evict_hdr_t              in_hdr;
  logic                    accept;
  logic                    out_fire;
  logic                    is_first;
  logic                    is_final;
  logic                    line_end;
  logic                    unused_hdr_last;

  assign {in_data, in_hdr} = in_pld;
  assign accept   = in_vld && (state_q == COLLECT);
  assign out_fire = (state_q == FULL) && out_rdy;
  assign is_first = (beat_cnt_q == '0);
  assign is_final = (beat_cnt_q == LAST_BEAT);
  // The captured last flag is never presented downstream.
  assign unused_hdr_last = hdr_q.last;

`ifdef VC_EVICT_RX_CHK_EN
  logic err_q;
  logic hdr_mismatch;
  logic beat_err;

  assign hdr_mismatch = !is_first &&
                        ((in_hdr.addr.tag   != hdr_q.addr.tag)   ||
                         (in_hdr.addr.index != hdr_q.addr.index) ||
                         (in_hdr.db_entry_id != hdr_q.db_entry_id));
  // Flags both an early last and a missing last on the final beat.
  assign beat_err = hdr_mismatch || (in_hdr.last != is_final);
  assign line_end = is_final || in_hdr.last;
  assign out_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (is_first ? 1'b0 : err_q) | beat_err;
    end
  end
`else
  assign line_end = is_final;
  assign out_err  = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && line_end) state_d = FULL;
      FULL:    if (out_rdy)            state_d = COLLECT;
      default:                         state_d = COLLECT;
    endcase
  end

  // NOTE: the line buffer is plain flops with reset, since out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
      hdr_q      <= '0;
      beats_q    <= '0;
      line_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (is_first) begin
          hdr_q  <= in_hdr;
          line_q <= {{((DS_N-1)*BUS_WIDTH){1'b0}}, in_data};
        end else begin
          for (int k = 1; k < DS_N; k++) begin
            if (beat_cnt_q == BC_W'(k)) line_q[k*BUS_WIDTH +: BUS_WIDTH] <= in_data;
          end
        end
        beat_cnt_q <= beat_cnt_q + BC_W'(1);
        if (line_end) beats_q <= {1'b0, beat_cnt_q} + (BC_W+1)'(1);
      end
      if (out_fire) begin
        beat_cnt_q <= '0;
        line_cnt_q <= line_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_rdy           = (state_q == COLLECT);
  assign out_vld          = (state_q == FULL);
  assign out_data         = line_q;
  assign out_addr         = hdr_q.addr;
  assign out_rob_entry_id = hdr_q.rob_entry_id;
  assign out_db_entry_id  = hdr_q.db_entry_id;
  assign out_txnid        = hdr_q.txnid;
  assign out_sideband     = hdr_q.sideband;
  assign out_beats        = beats_q;
  assign line_cnt         = line_cnt_q;

endmodule
